// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall sequencer: load-use bubbles, memory-wait freeze, flush gating, boot clear, watchdog and perf counters.
// Latency: control outputs combinational from registered state + current inputs; state, watchdog flag and counters update next cycle.
// Backpressure: an incomplete data-memory access (mem_req && !mem_ready) freezes the whole pipeline until mem_ready.
module hazard_sequencer #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  flush_req,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic [1:0]            state,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
    localparam logic [15:0]      WAIT_MAX  = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_wait_cnt;
    logic                  r_mem_timeout;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_lu_hazard;
    logic                  w_mem_stall;
    logic                  w_rs1_match;
    logic                  w_rs2_match;
    logic                  w_active;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rs1_match = (ex_rd == id_rs1);
    assign w_rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign w_lu_hazard = ex_mem_read && (ex_rd != '0) && (w_rs1_match || w_rs2_match);
    assign w_mem_stall = mem_req && !mem_ready;
    assign w_active    = (r_state != BOOT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        case (r_state)
            BOOT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                w_state_nxt  = RUN;
            end
            RUN, MEM_WAIT: begin
                // Freeze wins: ID is held, so a pending flush_req re-presents after the wait.
                if (w_mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else if (w_lu_hazard) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (flush_req) begin
                    if_id_flush = 1'b1;
                end
                w_state_nxt = w_mem_stall ? MEM_WAIT : RUN;
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                w_state_nxt  = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (r_state == MEM_WAIT) begin
                if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
                if (w_mem_stall && (r_wait_cnt == TIMEOUT_V)) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active && !pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_active && if_id_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign state        = r_state;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the 5-stage RISC-V core. It takes the ID-stage `flush` from `control_unit`, load-use hazard information from ID/EX, and the data-memory ready handshake. From these it drives the PC, IF/ID and ID/EX write/flush/bubble controls and a global pipeline freeze. It also performs a one-cycle pipeline clear after reset, runs a memory-wait watchdog, and keeps saturating stall and flush performance counters.

## Interface
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 32: performance counter width.
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before `mem_timeout` sets; must be ≥1 and fit in 16 bits.

One clock; reset is asynchronous and active-low.
- `clk`  in  1  core clock, rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `id_rs1`  in  REG_ADDR_W  rs1 of the instruction in ID.
- `id_rs2`  in  REG_ADDR_W  rs2 of the instruction in ID.
- `id_uses_rs2`  in  1  ID instruction reads rs2 (R-type, store, branch).
- `ex_rd`  in  REG_ADDR_W  rd of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `flush_req`  in  1  `flush` output of `control_unit` (mispredict or jump in ID).
- `mem_req`  in  1  MEM stage is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_ex_bubble`  out  1  zero control fields entering ID/EX.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `state`  out  2  FSM state: BOOT=00, RUN=01, MEM_WAIT=10.
- `mem_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `pc_write`=0 outside BOOT.
- `flush_count`  out  CNT_W  saturating count of cycles with `if_id_flush`=1 outside BOOT.

## Operation
- Internal signals:
  - `lu_hazard` = `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs1` || (`id_uses_rs2` && `ex_rd`==`id_rs2`)).
  - `mem_stall` = `mem_req` && !`mem_ready`.
- BOOT (reset state):
  - Outputs: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_bubble`=1, `pipe_freeze`=0.
  - All data inputs are ignored.
  - Next state is RUN unconditionally.
- RUN and MEM_WAIT share one output priority, evaluated each cycle:
  1. `mem_stall`: `pipe_freeze`=1, `pc_write`=0, `if_id_write`=0, flush/bubble=0. Flush is suppressed because ID is frozen and `flush_req` re-presents.
  2. else `lu_hazard`: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1, `if_id_flush`=0. Flush is suppressed because branch operands are stale.
  3. else `flush_req`: `if_id_flush`=1, `pc_write`=1, `if_id_write`=1.
  4. else all enables 1, flush/bubble/freeze 0.
- Transitions:
  - RUN→MEM_WAIT when `mem_stall`.
  - MEM_WAIT→RUN when `mem_ready`=1; that cycle is evaluated by priority rows 2–4.
  - MEM_WAIT stays while `mem_stall`.
  - MEM_WAIT with `mem_req`=0 (protocol violation) →RUN, no freeze.
- Watchdog:
  - 16-bit `wait_cnt` clears on any cycle not in MEM_WAIT and increments each MEM_WAIT cycle.
  - When `wait_cnt`==MEM_TIMEOUT and `mem_stall`, `mem_timeout` sets.
  - `mem_timeout` clears only on reset. The freeze continues regardless.
- Counters:
  - Each counter increments by 1 per qualifying cycle and holds at 2^CNT_W−1.
  - A load-use cycle and a mem-stall cycle each count once in `stall_cycles`.

## Timing
- Control outputs are combinational from the registered state and the current inputs. `state`, `mem_timeout` and the counters are registered.
- Counter and `mem_timeout` updates are visible the cycle after the qualifying cycle.
- `arst_n` low, at any time including mid-MEM_WAIT:
  - `state`=BOOT immediately, so control outputs take their BOOT values.
  - Counters, `wait_cnt` and `mem_timeout` go to 0.
- First rising edge after `arst_n` rises: state moves BOOT→RUN.
- Load-use costs exactly one bubble cycle; the hazard clears naturally once the load leaves EX.
- A memory wait of N cycles freezes the pipeline for exactly N cycles.

## Test plan
- Reset release, all inputs 0 → one BOOT cycle with `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=0; then RUN with all enables 1; `stall_cycles`=0.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 for one cycle → `pc_write`=0, `id_ex_bubble`=1; `stall_cycles`=1. Repeating with `ex_rd`=0 → no stall.
- `lu_hazard` and `flush_req` together → bubble only, `if_id_flush`=0. Next cycle `flush_req` alone → `if_id_flush`=1; `flush_count`=1.
- `mem_req`=1 with `mem_ready`=0 for 3 cycles, then `mem_ready`=1 → `pipe_freeze`=1 for exactly 3 cycles and `state`=10 for cycles 2–4; RUN after.
- MEM_TIMEOUT=4, `mem_req`=1, `mem_ready` held at 0 → `mem_timeout`=1 after the 5th MEM_WAIT cycle, freeze still asserted. Assert `arst_n`=0 mid-wait → BOOT immediately, flag cleared.
- CNT_W=4 with load-use forced for 20 cycles → `stall_cycles` saturates at 15.
